// File: rtl/prg_uploader.sv
// prg_uploader: reads the PROGND pointer from RAM, derives the BASIC program
// length and streams every program byte out on a valid/ready byte channel.
module prg_uploader #(
  parameter logic [24:0] PRG_START  = 25'h0008241,
  parameter logic [24:0] PTR_PROGND = 25'h00081BB,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_rd,
  output logic [24:0] o_addr,
  input  logic [7:0]  i_din,
  output logic        o_upload,
  output logic [15:0] o_up_len,
  output logic        o_up_valid,
  output logic [7:0]  o_up_data,
  input  logic        i_up_ready,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned CntW = 3;

  typedef enum logic [3:0] {
    StIdle,
    StRdLo,
    StWaitLo,
    StRdHi,
    StWaitHi,
    StCheck,
    StFetch,
    StWaitData,
    StSend,
    StFinish
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [CntW-1:0] r_wait_cnt;
  logic [7:0]      r_ptr_lo;
  logic [7:0]      r_ptr_hi;
  logic [15:0]     r_up_len;
  logic [15:0]     r_remaining;
  logic [24:0]     r_byte_addr;
  logic [7:0]      r_up_data;
  logic            r_up_valid;
  logic            r_error;

  logic            w_in_wait;
  logic            w_last_wait;
  logic [16:0]     w_len;
  logic            w_borrow;
  logic            w_accept;

  // Read data is valid in the last cycle of each wait state.
  assign w_in_wait   = (r_state == StWaitLo) || (r_state == StWaitHi) ||
                       (r_state == StWaitData);
  assign w_last_wait = (r_wait_cnt == CntW'(RD_LATENCY - 1));
  // 17-bit subtract so bit 16 flags PROGND below the program start.
  assign w_len       = {1'b0, r_ptr_hi, r_ptr_lo} - {1'b0, PRG_START[15:0]};
  assign w_borrow    = w_len[16];
  assign w_accept    = r_up_valid && i_up_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (i_start) w_state_next = StRdLo;
      StRdLo:     w_state_next = StWaitLo;
      StWaitLo:   if (w_last_wait) w_state_next = StRdHi;
      StRdHi:     w_state_next = StWaitHi;
      StWaitHi:   if (w_last_wait) w_state_next = StCheck;
      StCheck: begin
        if (w_borrow || (w_len[15:0] == 16'h0000)) begin
          w_state_next = StFinish;
        end else begin
          w_state_next = StFetch;
        end
      end
      StFetch:    w_state_next = StWaitData;
      StWaitData: if (w_last_wait) w_state_next = StSend;
      StSend: begin
        if (w_accept) begin
          w_state_next = (r_remaining > 16'd1) ? StFetch : StFinish;
        end
      end
      StFinish:   w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Datapath: pointer capture, length, byte address and stream register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wait_cnt  <= '0;
      r_ptr_lo    <= '0;
      r_ptr_hi    <= '0;
      r_up_len    <= '0;
      r_remaining <= '0;
      r_byte_addr <= '0;
      r_up_data   <= '0;
      r_up_valid  <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_in_wait && !w_last_wait) begin
        r_wait_cnt <= r_wait_cnt + CntW'(1);
      end else begin
        r_wait_cnt <= '0;
      end

      case (r_state)
        StIdle: begin
          if (i_start) r_error <= 1'b0;
        end
        StWaitLo: begin
          if (w_last_wait) r_ptr_lo <= i_din;
        end
        StWaitHi: begin
          if (w_last_wait) r_ptr_hi <= i_din;
        end
        StCheck: begin
          if (w_borrow) begin
            r_error <= 1'b1;
          end else if (w_len[15:0] != 16'h0000) begin
            r_up_len    <= w_len[15:0];
            r_remaining <= w_len[15:0];
            r_byte_addr <= PRG_START;
          end
        end
        StWaitData: begin
          if (w_last_wait) begin
            r_up_data  <= i_din;
            r_up_valid <= 1'b1;
          end
        end
        StSend: begin
          if (w_accept) begin
            r_up_valid  <= 1'b0;
            r_byte_addr <= r_byte_addr + 25'd1;
            r_remaining <= r_remaining - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    o_busy     = (r_state != StIdle);
    o_rd       = 1'b0;
    o_addr     = '0;
    o_upload   = 1'b0;
    o_done     = 1'b0;
    o_up_len   = r_up_len;
    o_up_valid = r_up_valid;
    o_up_data  = r_up_data;
    o_error    = r_error;
    case (r_state)
      StRdLo: begin
        o_rd   = 1'b1;
        o_addr = PTR_PROGND;
      end
      StWaitLo: o_addr = PTR_PROGND;
      StRdHi: begin
        o_rd   = 1'b1;
        o_addr = PTR_PROGND + 25'd1;
      end
      StWaitHi: o_addr = PTR_PROGND + 25'd1;
      StFetch: begin
        o_rd     = 1'b1;
        o_addr   = r_byte_addr;
        o_upload = 1'b1;
      end
      StWaitData: begin
        o_addr   = r_byte_addr;
        o_upload = 1'b1;
      end
      StSend:   o_upload = 1'b1;
      StFinish: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prg_uploader.sv
// Directed bench for prg_uploader with a latency-2 RAM model and a stream monitor.
module tb_prg_uploader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        up_ready = 1'b0;
  logic        busy, rd, upload, up_valid, done, error;
  logic [24:0] addr;
  logic [15:0] up_len;
  logic [7:0]  up_data;

  prg_uploader dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_rd       (rd),
    .o_addr     (addr),
    .i_din      (din),
    .o_upload   (upload),
    .o_up_len   (up_len),
    .o_up_valid (up_valid),
    .o_up_data  (up_data),
    .i_up_ready (up_ready),
    .o_done     (done),
    .o_error    (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: PROGND pointer plus a small program area
  logic [15:0] progond = 16'h0000;
  logic [7:0]  prog [16];

  function automatic logic [7:0] mem_rd(input logic [24:0] a);
    int idx;
    if (a == 25'h81BB) return progond[7:0];
    if (a == 25'h81BC) return progond[15:8];
    if (a >= 25'h8241 && a < 25'h8251) begin
      idx = int'(a - 25'h8241);
      return prog[idx];
    end
    return 8'hEE;
  endfunction

  // Data is driven only in the one cycle it is valid; junk otherwise.
  logic        p_vld = 1'b0;
  logic [24:0] p_addr = '0;
  always @(posedge clk) begin
    p_vld  <= rd;
    p_addr <= addr;
    din    <= p_vld ? mem_rd(p_addr) : 8'hA5;
  end

  // Ready generator: mode 0 always ready, mode 1 ready one cycle in three
  int rmode = 0;
  int rcnt  = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 0) begin
      up_ready = 1'b1;
    end else begin
      up_ready = (rcnt % 3 == 0);
      rcnt++;
    end
  end

  // Monitor
  logic [24:0] rd_q[$];
  logic [7:0]  beat_q[$];
  int          ndone = 0;
  int          nupl = 0;
  int          viol = 0;
  logic [15:0] len_seen = '0;
  bit          len_ok = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_acc = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (rd) rd_q.push_back(addr);
      if (up_valid && up_ready) beat_q.push_back(up_data);
      if (done) begin
        ndone++;
        if (!busy) viol++;
      end
      if (upload) begin
        if (len_ok && up_len != len_seen) viol++;
        len_seen = up_len;
        len_ok   = 1'b1;
        nupl++;
      end
      if (prev_valid && !prev_acc) begin
        if (!up_valid) viol++;
        if (up_data != prev_data) viol++;
      end
      prev_valid = up_valid;
      prev_acc   = up_valid && up_ready;
      prev_data  = up_data;
    end
  end

  task automatic clear_logs();
    rd_q.delete();
    beat_q.delete();
    ndone    = 0;
    nupl     = 0;
    viol     = 0;
    len_ok   = 1'b0;
    len_seen = '0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"},   32'(busy), 0);
    check_eq({tag, "_rd"},     32'(rd), 0);
    check_eq({tag, "_addr"},   32'(addr), 0);
    check_eq({tag, "_upload"}, 32'(upload), 0);
    check_eq({tag, "_uplen"},  32'(up_len), 0);
    check_eq({tag, "_valid"},  32'(up_valid), 0);
    check_eq({tag, "_data"},   32'(up_data), 0);
    check_eq({tag, "_done"},   32'(done), 0);
    check_eq({tag, "_error"},  32'(error), 0);
  endtask

  // Expected read addresses and beats for the 3-byte program at 8241
  logic [24:0] exp_rd [5];
  logic [7:0]  exp_beat [3];

  task automatic check_logs(input string tag, input int n_rd, input int n_beat, input int n_done);
    check_eq({tag, "_nrd"},   32'(rd_q.size()), 32'(n_rd));
    check_eq({tag, "_nbeat"}, 32'(beat_q.size()), 32'(n_beat));
    check_eq({tag, "_ndone"}, 32'(ndone), 32'(n_done));
    check_eq({tag, "_viol"},  32'(viol), 0);
    for (int i = 0; i < n_rd && i < rd_q.size(); i++)
      check_eq({tag, "_rdaddr"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    for (int i = 0; i < n_beat && i < beat_q.size(); i++)
      check_eq({tag, "_beat"}, 32'(beat_q[i]), 32'(exp_beat[i]));
  endtask

  // One save request; p1/p2 are cycles at which a stray start pulse is injected.
  task automatic run_save(input logic [15:0] pnd, input int mode, input int p1, input int p2,
                          output int done_k);
    int k;
    bit seen;
    progond = pnd;
    rmode   = mode;
    rcnt    = 0;
    clear_logs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 1;
    check_eq("c1_busy", 32'(busy), 1);
    check_eq("c1_rd",   32'(rd), 1);
    check_eq("c1_addr", 32'(addr), 32'h81BB);
    check_eq("c1_err",  32'(error), 0);
    seen   = 1'b0;
    done_k = -1;
    while (!seen && k < 400) begin
      @(negedge clk);
      if (done) begin
        seen   = 1'b1;
        done_k = k;
      end else begin
        @(posedge clk); #1;
        k++;
        start = (k == p1) || (k == p2);
      end
    end
    start = 1'b0;
    check_eq("done_seen", 32'(seen), 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  int  dk;
  bit  found;

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 8'h0A + 8'(i);
    exp_rd   = '{25'h81BB, 25'h81BC, 25'h8241, 25'h8242, 25'h8243};
    exp_beat = '{8'h0A, 8'h0B, 8'h0C};

    #12 check_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic 3-byte program, always ready
    run_save(16'h8244, 0, 0, 0, dk);
    check_eq("t1_donek", 32'(dk), 20);
    check_logs("t1", 5, 3, 1);
    check_eq("t1_len",   32'(len_seen), 3);
    check_eq("t1_nupl",  32'(nupl), 12);
    check_eq("t1_err",   32'(error), 0);
    check_eq("t1_idle",  32'(busy), 0);

    // Same program with stalls
    run_save(16'h8244, 1, 0, 0, dk);
    check_logs("t2", 5, 3, 1);
    check_eq("t2_len",   32'(len_seen), 3);

    // Zero-length program
    run_save(16'h8241, 0, 0, 0, dk);
    check_eq("t3_donek", 32'(dk), 8);
    check_logs("t3", 2, 0, 1);
    check_eq("t3_nupl",  32'(nupl), 0);
    check_eq("t3_err",   32'(error), 0);

    // PROGND below program start
    run_save(16'h8000, 0, 0, 0, dk);
    check_eq("t4_donek", 32'(dk), 8);
    check_logs("t4", 2, 0, 1);
    check_eq("t4_nupl",  32'(nupl), 0);
    check_eq("t4_err",   32'(error), 1);
    repeat (5) @(posedge clk);
    #1 check_eq("t4_sticky", 32'(error), 1);

    // Valid request clears the error (checked at cycle 1 inside run_save)
    run_save(16'h8244, 0, 0, 0, dk);
    check_logs("t5", 5, 3, 1);
    check_eq("t5_err",   32'(error), 0);

    // Reset during the second byte
    progond = 16'h8244;
    rmode   = 0;
    clear_logs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rd && addr == 25'h8242) found = 1'b1;
    end
    check_eq("t6_found", 32'(found), 1);
    #2 reset_n = 1'b0;
    #1 check_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("t6_nodone", 32'(ndone), 0);
    run_save(16'h8244, 0, 0, 0, dk);
    check_eq("t6_donek", 32'(dk), 20);
    check_logs("t6", 5, 3, 1);

    // Start pulses while busy (RD_HI at cycle 4, first SEND at cycle 11)
    run_save(16'h8244, 0, 4, 11, dk);
    repeat (30) @(posedge clk);
    #1;
    check_eq("t7_donek", 32'(dk), 20);
    check_logs("t7", 5, 3, 1);
    check_eq("t7_idle",  32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
